// File: rtl/cam_array.sv
// Content-addressable storage: DEPTH entries of WIDTH-bit data with valid bits.
// Ports: clk_i/reset_i, read/write/search requests in, registered results and entry count out.
module cam_array #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  read_enable_i,
  input  logic [ADDR_WIDTH-1:0] read_index_i,
  input  logic                  write_enable_i,
  input  logic [ADDR_WIDTH-1:0] write_index_i,
  input  logic [WIDTH-1:0]      write_data_i,
  input  logic                  search_enable_i,
  input  logic [WIDTH-1:0]      search_data_i,
  output logic                  read_valid_o,
  output logic [WIDTH-1:0]      read_value_o,
  output logic                  search_valid_o,
  output logic                  search_hit_o,
  output logic [ADDR_WIDTH-1:0] search_index_o,
  output logic [ADDR_WIDTH:0]   entry_count_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0]      data_q [DEPTH];
  logic [WIDTH-1:0]      data_d [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  read_valid_q, read_valid_d;
  logic [WIDTH-1:0]      read_value_q, read_value_d;
  logic                  search_valid_q, search_valid_d;
  logic                  search_hit_q, search_hit_d;
  logic [ADDR_WIDTH-1:0] search_index_q, search_index_d;

  logic                  do_read, do_write, do_search;
  logic                  match_hit;
  logic [ADDR_WIDTH-1:0] match_idx;

  // Fixed priority read > write > search; losers are dropped.
  assign do_read   = read_enable_i;
  assign do_write  = write_enable_i & ~read_enable_i;
  assign do_search = search_enable_i & ~read_enable_i
                   & ~write_enable_i;

  // Walk down so the lowest matching index wins.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && data_q[i] == search_data_i) begin
        match_hit = 1'b1;
        match_idx = ADDR_WIDTH'(i);
      end
    end
  end

  always_comb begin
    data_d         = data_q;
    valid_d        = valid_q;
    count_d        = count_q;
    read_valid_d   = read_valid_q;
    read_value_d   = read_value_q;
    search_valid_d = 1'b0;
    search_hit_d   = search_hit_q;
    search_index_d = search_index_q;
    unique case (1'b1)
      do_read: begin
        read_valid_d = valid_q[read_index_i];
        read_value_d = valid_q[read_index_i]
                     ? data_q[read_index_i] : '0;
      end
      do_write: begin
        data_d[write_index_i]  = write_data_i;
        valid_d[write_index_i] = 1'b1;
        // Only fresh entries add to the count.
        if (!valid_q[write_index_i])
          count_d = count_q + (ADDR_WIDTH + 1)'(1);
      end
      do_search: begin
        search_valid_d = 1'b1;
        search_hit_d   = match_hit;
        search_index_d = match_idx;
      end
      default: ;
    endcase
  end

  // Storage is left unreset; valid bits gate it.
  always_ff @(posedge clk_i) begin
    if (!reset_i) data_q <= data_d;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q        <= '0;
      count_q        <= '0;
      read_valid_q   <= 1'b0;
      read_value_q   <= '0;
      search_valid_q <= 1'b0;
      search_hit_q   <= 1'b0;
      search_index_q <= '0;
    end else begin
      valid_q        <= valid_d;
      count_q        <= count_d;
      read_valid_q   <= read_valid_d;
      read_value_q   <= read_value_d;
      search_valid_q <= search_valid_d;
      search_hit_q   <= search_hit_d;
      search_index_q <= search_index_d;
    end
  end

  assign read_valid_o   = read_valid_q;
  assign read_value_o   = read_value_q;
  assign search_valid_o = search_valid_q;
  assign search_hit_o   = search_hit_q;
  assign search_index_o = search_index_q;
  assign entry_count_o  = count_q;

endmodule

// File: tb/tb_cam_array.sv
// Self-checking bench for cam_array: directed steps then random ops
// against an array-based reference model.
module tb_cam_array;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int D  = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset_i = 1'b0;
  logic          read_enable_i = 1'b0;
  logic [AW-1:0] read_index_i = '0;
  logic          write_enable_i = 1'b0;
  logic [AW-1:0] write_index_i = '0;
  logic [W-1:0]  write_data_i = '0;
  logic          search_enable_i = 1'b0;
  logic [W-1:0]  search_data_i = '0;
  logic          read_valid_o;
  logic [W-1:0]  read_value_o;
  logic          search_valid_o;
  logic          search_hit_o;
  logic [AW-1:0] search_index_o;
  logic [AW:0]   entry_count_o;

  cam_array #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .read_enable_i(read_enable_i),
    .read_index_i(read_index_i),
    .write_enable_i(write_enable_i),
    .write_index_i(write_index_i),
    .write_data_i(write_data_i),
    .search_enable_i(search_enable_i),
    .search_data_i(search_data_i),
    .read_valid_o(read_valid_o),
    .read_value_o(read_value_o),
    .search_valid_o(search_valid_o),
    .search_hit_o(search_hit_o),
    .search_index_o(search_index_o),
    .entry_count_o(entry_count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit        m_valid [D];
  bit [31:0] m_data  [D];
  int        m_count;
  bit        e_rv, e_sv, e_sh;
  bit [31:0] e_rval;
  int        e_si;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit rst, input bit re, input int ri,
                       input bit we, input int wi, input bit [31:0] wd,
                       input bit se, input bit [31:0] sd);
    e_sv = 0;
    if (rst) begin
      foreach (m_valid[i]) m_valid[i] = 0;
      m_count = 0;
      e_rv = 0; e_rval = 0; e_sh = 0; e_si = 0;
    end else if (re) begin
      e_rv = m_valid[ri];
      e_rval = m_valid[ri] ? m_data[ri] : 0;
    end else if (we) begin
      if (!m_valid[wi]) m_count++;
      m_valid[wi] = 1;
      m_data[wi] = wd;
    end else if (se) begin
      e_sv = 1; e_sh = 0; e_si = 0;
      for (int i = 0; i < D; i++)
        if (m_valid[i] && m_data[i] == sd && !e_sh) begin
          e_sh = 1; e_si = i;
        end
    end
  endtask

  task automatic step(input bit rst, input bit re, input int ri,
                      input bit we, input int wi, input bit [31:0] wd,
                      input bit se, input bit [31:0] sd);
    @(negedge clk);
    reset_i = rst;
    read_enable_i = re;  read_index_i = AW'(ri);
    write_enable_i = we; write_index_i = AW'(wi);
    write_data_i = wd;
    search_enable_i = se; search_data_i = sd;
    model(rst, re, ri, we, wi, wd, se, sd);
    @(posedge clk);
    #1;
    chk("read_valid", 64'(read_valid_o), 64'(e_rv));
    chk("read_value", 64'(read_value_o), 64'(e_rval));
    chk("search_valid", 64'(search_valid_o), 64'(e_sv));
    chk("search_hit", 64'(search_hit_o), 64'(e_sh));
    chk("search_index", 64'(search_index_o), 64'(e_si));
    chk("entry_count", 64'(entry_count_o), 64'(m_count));
  endtask

  task automatic rd(input int i);
    step(0, 1, i, 0, 0, 0, 0, 0);
  endtask
  task automatic wr(input int i, input bit [31:0] d);
    step(0, 0, 0, 1, i, d, 0, 0);
  endtask
  task automatic sr(input bit [31:0] d);
    step(0, 0, 0, 0, 0, 0, 1, d);
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  bit [31:0] pool [8];

  initial begin
    m_count = 0;
    step(1, 1, 3, 1, 3, 32'h1, 1, 32'h1);
    chk("cnt_after_reset", 64'(entry_count_o), 64'd0);
    rd(3);
    chk("rd3_invalid", 64'(read_valid_o), 64'd0);
    wr(7, 32'hDEADBEEF);
    rd(7);
    chk("rd7_value", 64'(read_value_o), 64'hDEADBEEF);
    wr(9, 32'h1234);
    wr(4, 32'h1234);
    sr(32'h1234);
    chk("search_lowest", 64'(search_index_o), 64'd4);
    wr(4, 32'h5555);
    sr(32'h1234);
    chk("search_after_rewrite", 64'(search_index_o), 64'd9);
    chk("count_stays", 64'(entry_count_o), 64'd3);
    sr(32'hCAFE);
    idle();
    chk("sv_drops", 64'(search_valid_o), 64'd0);
    step(0, 1, 7, 1, 2, 32'hAA, 1, 32'hAA);
    rd(2);
    chk("dropped_write", 64'(read_valid_o), 64'd0);
    for (int i = 0; i < D; i++) wr(i, 32'h100 + i);
    chk("count_full", 64'(entry_count_o), 64'd32);
    wr(5, 32'h77);
    sr(32'h77);
    sr(32'h100 + 31);
    chk("search_top", 64'(search_index_o), 64'd31);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    sr(32'h100 + 10);
    chk("miss_after_reset", 64'(search_hit_o), 64'd0);
    for (int i = 0; i < 8; i++) pool[i] = $urandom;
    for (int n = 0; n < 600; n++) begin
      int op;
      op = $urandom_range(0, 99);
      step(op < 2, $urandom_range(0, 3) == 0, $urandom_range(0, D - 1),
           $urandom_range(0, 1) == 0, $urandom_range(0, D - 1),
           pool[$urandom_range(0, 7)],
           $urandom_range(0, 1) == 0, pool[$urandom_range(0, 7)]);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
